// File: rtl/mips_instr_encoder_pkg.sv
// Shared op enum, MIPS opcode/funct values and the pure encode function used by the loader.
package mips_enc_pkg;

    typedef enum logic [4:0] {
        OP_NOP, OP_ADD, OP_AND, OP_OR, OP_SUB, OP_SLT, OP_XOR, OP_NOR, OP_SLL, OP_SRL, OP_JR,
        OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_BEQ, OP_LW, OP_SW, OP_LUI,
        OP_J, OP_JAL, OP_FADD, OP_FSUB, OP_FNEG
    } op_e;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DRAIN, ST_DONE} state_e;

    localparam logic [5:0] OPC_SPECIAL = 6'h00, OPC_J = 6'h02, OPC_JAL = 6'h03, OPC_BEQ = 6'h04,
                           OPC_ADDI = 6'h08, OPC_SLTI = 6'h0A, OPC_ANDI = 6'h0C, OPC_ORI = 6'h0D,
                           OPC_XORI = 6'h0E, OPC_LUI = 6'h0F, OPC_COP1 = 6'h11, OPC_LW = 6'h23,
                           OPC_SW = 6'h2B;
    localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_JR = 6'h08, FN_ADD = 6'h20,
                           FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR = 6'h25, FN_XOR = 6'h26,
                           FN_NOR = 6'h27, FN_SLT = 6'h2A;
    localparam logic [5:0] FFN_ADD = 6'h00, FFN_SUB = 6'h01, FFN_NEG = 6'h07;

    typedef struct packed {
        logic        ok;
        logic [31:0] word;
    } enc_t;

    // FP ops reuse the generic fields: ft=rt, fs=rd, fd=shamt.
    function automatic enc_t encode(logic [4:0] op, logic [4:0] rs, logic [4:0] rt,
                                    logic [4:0] rd, logic [4:0] sh, logic [4:0] fmt,
                                    logic [15:0] imm, logic [25:0] tgt);
        enc_t e;
        e.ok   = 1'b1;
        e.word = '0;
        case (op)
            OP_NOP:  e.word = '0;
            OP_ADD:  e.word = {OPC_SPECIAL, rs, rt, rd, 5'd0, FN_ADD};
            OP_AND:  e.word = {OPC_SPECIAL, rs, rt, rd, 5'd0, FN_AND};
            OP_OR:   e.word = {OPC_SPECIAL, rs, rt, rd, 5'd0, FN_OR};
            OP_SUB:  e.word = {OPC_SPECIAL, rs, rt, rd, 5'd0, FN_SUB};
            OP_SLT:  e.word = {OPC_SPECIAL, rs, rt, rd, 5'd0, FN_SLT};
            OP_XOR:  e.word = {OPC_SPECIAL, rs, rt, rd, 5'd0, FN_XOR};
            OP_NOR:  e.word = {OPC_SPECIAL, rs, rt, rd, 5'd0, FN_NOR};
            OP_SLL:  e.word = {OPC_SPECIAL, 5'd0, rt, rd, sh, FN_SLL};
            OP_SRL:  e.word = {OPC_SPECIAL, 5'd0, rt, rd, sh, FN_SRL};
            OP_JR:   e.word = {OPC_SPECIAL, rs, 15'd0, FN_JR};
            OP_ADDI: e.word = {OPC_ADDI, rs, rt, imm};
            OP_ANDI: e.word = {OPC_ANDI, rs, rt, imm};
            OP_ORI:  e.word = {OPC_ORI, rs, rt, imm};
            OP_XORI: e.word = {OPC_XORI, rs, rt, imm};
            OP_SLTI: e.word = {OPC_SLTI, rs, rt, imm};
            OP_BEQ:  e.word = {OPC_BEQ, rs, rt, imm};
            OP_LW:   e.word = {OPC_LW, rs, rt, imm};
            OP_SW:   e.word = {OPC_SW, rs, rt, imm};
            OP_LUI:  e.word = {OPC_LUI, 5'd0, rt, imm};
            OP_J:    e.word = {OPC_J, tgt};
            OP_JAL:  e.word = {OPC_JAL, tgt};
            OP_FADD: e.word = {OPC_COP1, fmt, rt, rd, sh, FFN_ADD};
            OP_FSUB: e.word = {OPC_COP1, fmt, rt, rd, sh, FFN_SUB};
            OP_FNEG: e.word = {OPC_COP1, fmt, 5'd0, rd, sh, FFN_NEG};
            default: e.ok = 1'b0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/mips_instr_encoder_if.sv
// Request and instruction-memory write bus between a program source and the encoder.
interface mips_enc_if #(parameter int ADDR_W = 32);
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        in_op, in_rs, in_rt, in_rd, in_shamt, in_fmt;
    logic [15:0]       in_imm;
    logic [25:0]       in_target;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              imem_ack;

    modport slave (
        input  in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_fmt, in_imm, in_target, imem_ack,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
    modport master (
        output in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_fmt, in_imm, in_target, imem_ack,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/mips_instr_encoder_fifo.sv
// Synchronous FIFO for encoded words; clr_i empties it without touching storage.
module mips_enc_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wptr_q, rptr_q;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign dout_o  = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n || clr_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push_i && !full_o) wptr_q <= wptr_q + 1'b1;
            if (pop_i && !empty_o) rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !full_o) mem_q[wptr_q[AW-1:0]] <= din_i;
    end
endmodule

// File: rtl/mips_instr_encoder.sv
// Program loader: encodes symbolic requests, buffers them and writes them sequentially to imem.
module mips_instr_encoder
    import mips_enc_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int                MAX_WORDS  = 256,
    parameter int                FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        finish,
    mips_enc_if.slave   bus,
    output logic        busy,
    output logic        done,
    output logic [15:0] word_count,
    output logic        err_badop,
    output logic        err_overflow
);
    state_e            state_q, state_d;
    logic              enc_vld_q, enc_vld_d;
    logic [31:0]       enc_word_q, enc_word_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              badop_q, badop_d, ovf_q, ovf_d;
    logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [31:0]       fifo_dout;
    logic              writing, accept, at_max, wr_fire;
    enc_t              enc;

    assign enc = encode(bus.in_op, bus.in_rs, bus.in_rt, bus.in_rd, bus.in_shamt, bus.in_fmt,
                        bus.in_imm, bus.in_target);

    assign writing      = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
    assign bus.in_ready = (state_q == ST_LOAD) && !start && (!enc_vld_q || !fifo_full);
    assign accept       = bus.in_valid && bus.in_ready;
    assign fifo_push    = enc_vld_q && !fifo_full;
    assign at_max       = (cnt_q == 16'(MAX_WORDS));
    // At the word limit the head is discarded instead of written, so the address never wraps.
    assign bus.imem_we  = writing && !fifo_empty && !at_max;
    assign wr_fire      = bus.imem_we && bus.imem_ack;
    assign fifo_pop     = writing && !fifo_empty && (at_max || bus.imem_ack);

    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = fifo_dout;
    assign busy           = writing;
    assign done           = (state_q == ST_DONE);
    assign word_count     = cnt_q;
    assign err_badop      = badop_q;
    assign err_overflow   = ovf_q;

    mips_enc_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (start),
        .push_i (fifo_push),
        .din_i  (enc_word_q),
        .pop_i  (fifo_pop),
        .dout_o (fifo_dout),
        .full_o (fifo_full),
        .empty_o(fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        enc_vld_d  = enc_vld_q;
        enc_word_d = enc_word_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        badop_d    = badop_q;
        ovf_d      = ovf_q;
        if (fifo_push) enc_vld_d = 1'b0;
        if (accept) begin
            if (enc.ok) begin
                enc_vld_d  = 1'b1;
                enc_word_d = enc.word;
            end else begin
                badop_d = 1'b1;
            end
        end
        if (wr_fire) begin
            addr_d = addr_q + ADDR_W'(4);
            cnt_d  = cnt_q + 16'd1;
        end
        if (fifo_pop && at_max) ovf_d = 1'b1;
        case (state_q)
            ST_LOAD:  if (finish) state_d = ST_DRAIN;
            ST_DRAIN: if (fifo_empty && !enc_vld_q) state_d = ST_DONE;
            default:  ;
        endcase
        // start overrides everything, including a same-cycle finish.
        if (start) begin
            state_d   = ST_LOAD;
            enc_vld_d = 1'b0;
            addr_d    = BASE_ADDR;
            cnt_d     = '0;
            badop_d   = 1'b0;
            ovf_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            enc_vld_q  <= 1'b0;
            enc_word_q <= '0;
            addr_q     <= BASE_ADDR;
            cnt_q      <= '0;
            badop_q    <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            enc_vld_q  <= enc_vld_d;
            enc_word_q <= enc_word_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            badop_q    <= badop_d;
            ovf_q      <= ovf_d;
        end
    end
endmodule

// File: tb/tb_mips_instr_encoder.sv
// Directed bench: encoding table, latency, backpressure, bad op, restart and overflow.
module tb_mips_instr_encoder;
    import mips_enc_pkg::*;

    typedef struct {
        logic [4:0]  op, rs, rt, rd, sh, fmt;
        logic [15:0] imm;
        logic [25:0] tgt;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 16;

    logic clk = 1'b0, rst_n = 1'b0;
    logic start = 1'b0, finish = 1'b0, start2 = 1'b0, finish2 = 1'b0;
    logic ack_en = 1'b0, sel = 1'b0;
    logic busy, done, err_badop, err_overflow, busy2, done2, err_badop2, err_overflow2;
    logic [15:0] word_count, word_count2;
    int checks = 0, errors = 0;
    int wr_n = 0, wr2_n = 0;
    logic [31:0] log_d [64];
    logic [31:0] log_a [64];
    vec_t vecs [NV];

    always #5 clk = ~clk;

    mips_enc_if #(.ADDR_W(32)) bus ();
    mips_enc_if #(.ADDR_W(32)) bus2 ();

    assign bus.imem_ack   = ack_en;
    assign bus2.imem_ack  = 1'b1;
    assign bus2.in_op     = bus.in_op;
    assign bus2.in_rs     = bus.in_rs;
    assign bus2.in_rt     = bus.in_rt;
    assign bus2.in_rd     = bus.in_rd;
    assign bus2.in_shamt  = bus.in_shamt;
    assign bus2.in_fmt    = bus.in_fmt;
    assign bus2.in_imm    = bus.in_imm;
    assign bus2.in_target = bus.in_target;

    mips_instr_encoder #(.ADDR_W(32), .BASE_ADDR(32'h100), .MAX_WORDS(256), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .finish(finish), .bus(bus),
        .busy(busy), .done(done), .word_count(word_count),
        .err_badop(err_badop), .err_overflow(err_overflow)
    );

    mips_instr_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0), .MAX_WORDS(2), .FIFO_DEPTH(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .finish(finish2), .bus(bus2),
        .busy(busy2), .done(done2), .word_count(word_count2),
        .err_badop(err_badop2), .err_overflow(err_overflow2)
    );

    always @(posedge clk) begin
        if (bus.imem_we && bus.imem_ack) begin
            log_d[wr_n[5:0]] <= bus.imem_wdata;
            log_a[wr_n[5:0]] <= bus.imem_addr;
            wr_n <= wr_n + 1;
        end
        if (bus2.imem_we && bus2.imem_ack) wr2_n <= wr2_n + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic pulse(input int which);
        @(negedge clk);
        case (which)
            0: start = 1'b1;
            1: finish = 1'b1;
            2: start2 = 1'b1;
            default: finish2 = 1'b1;
        endcase
        @(negedge clk);
        start = 1'b0; finish = 1'b0; start2 = 1'b0; finish2 = 1'b0;
    endtask

    // Returns one time unit after the accepting edge.
    task automatic send(input vec_t v);
        bit ok = 1'b0;
        @(negedge clk);
        bus.in_op = v.op; bus.in_rs = v.rs; bus.in_rt = v.rt; bus.in_rd = v.rd;
        bus.in_shamt = v.sh; bus.in_fmt = v.fmt; bus.in_imm = v.imm; bus.in_target = v.tgt;
        if (sel) bus2.in_valid = 1'b1; else bus.in_valid = 1'b1;
        for (int n = 0; n < 50 && !ok; n++) begin
            if (sel ? bus2.in_ready : bus.in_ready) ok = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (ok) begin
            @(posedge clk);
            #1;
        end else begin
            errors++;
            $display("FAIL send accept: in_ready 0 for 50 cycles, expected 1");
        end
        bus.in_valid = 1'b0;
        bus2.in_valid = 1'b0;
    endtask

    task automatic wait_done(input bit second);
        bit ok = 1'b0;
        for (int n = 0; n < 300 && !ok; n++) begin
            @(negedge clk);
            if (second ? done2 : done) ok = 1'b1;
        end
        chk(second ? "done2 reached" : "done reached", {31'd0, ok}, 32'd1);
    endtask

    initial begin
        int base, acc;
        logic [31:0] hold_a, hold_d;
        vec_t v;
        vecs[0]  = '{OP_ADD,  5'd1,  5'd2,  5'd3,  5'd0, 5'd0,  16'h0000, 26'h0,       32'h00221820};
        vecs[1]  = '{OP_LW,   5'd29, 5'd8,  5'd0,  5'd0, 5'd0,  16'h0004, 26'h0,       32'h8FA80004};
        vecs[2]  = '{OP_JR,   5'd31, 5'd5,  5'd7,  5'd3, 5'd0,  16'h0000, 26'h0,       32'h03E00008};
        vecs[3]  = '{OP_FADD, 5'd0,  5'd2,  5'd4,  5'd6, 5'd16, 16'h0000, 26'h0,       32'h46022180};
        vecs[4]  = '{OP_J,    5'd0,  5'd0,  5'd0,  5'd0, 5'd0,  16'h0000, 26'h100000,  32'h08100000};
        vecs[5]  = '{OP_SLL,  5'd9,  5'd2,  5'd3,  5'd4, 5'd0,  16'h0000, 26'h0,       32'h00021900};
        vecs[6]  = '{OP_SUB,  5'd4,  5'd5,  5'd6,  5'd3, 5'd0,  16'h0000, 26'h0,       32'h00853022};
        vecs[7]  = '{OP_LUI,  5'd7,  5'd1,  5'd0,  5'd0, 5'd0,  16'h1234, 26'h0,       32'h3C011234};
        vecs[8]  = '{OP_BEQ,  5'd1,  5'd2,  5'd0,  5'd0, 5'd0,  16'hFFFF, 26'h0,       32'h1022FFFF};
        vecs[9]  = '{OP_FNEG, 5'd0,  5'd3,  5'd2,  5'd1, 5'd17, 16'h0000, 26'h0,       32'h46201047};
        vecs[10] = '{OP_JAL,  5'd0,  5'd0,  5'd0,  5'd0, 5'd0,  16'h0000, 26'h3FFFFFF, 32'h0FFFFFFF};
        vecs[11] = '{OP_NOR,  5'd31, 5'd31, 5'd31, 5'd0, 5'd0,  16'h0000, 26'h0,       32'h03FFF827};
        vecs[12] = '{OP_ORI,  5'd2,  5'd3,  5'd9,  5'd0, 5'd0,  16'h00FF, 26'h0,       32'h344300FF};
        vecs[13] = '{OP_FSUB, 5'd0,  5'd1,  5'd2,  5'd3, 5'd16, 16'h0000, 26'h0,       32'h460110C1};
        vecs[14] = '{OP_SW,   5'd29, 5'd31, 5'd0,  5'd0, 5'd0,  16'h0008, 26'h0,       32'hAFBF0008};
        vecs[15] = '{OP_NOP,  5'd3,  5'd4,  5'd5,  5'd6, 5'd7,  16'h5555, 26'h0,       32'h00000000};

        bus.in_valid = 1'b0; bus2.in_valid = 1'b0;
        bus.in_op = '0; bus.in_rs = '0; bus.in_rt = '0; bus.in_rd = '0;
        bus.in_shamt = '0; bus.in_fmt = '0; bus.in_imm = '0; bus.in_target = '0;

        // Reset, with a raw ack and a request present while idle.
        ack_en = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bus.in_valid = 1'b1;
        @(negedge clk);
        chk("reset imem_addr", bus.imem_addr, 32'h100);
        chk("reset imem_we", {31'd0, bus.imem_we}, 32'd0);
        chk("reset busy/done", {30'd0, busy, done}, 32'd0);
        chk("reset errs", {30'd0, err_badop, err_overflow}, 32'd0);
        chk("idle in_ready", {31'd0, bus.in_ready}, 32'd0);
        repeat (2) @(negedge clk);
        chk("idle ack ignored count", {16'd0, word_count}, 32'd0);
        chk("idle ack ignored addr", bus.imem_addr, 32'h100);
        bus.in_valid = 1'b0;

        // First-word latency: accept edge N, imem_we after N+1.
        ack_en = 1'b0;
        pulse(0);
        chk("start busy", {31'd0, busy}, 32'd1);
        send(vecs[0]);
        chk("lat we after accept", {31'd0, bus.imem_we}, 32'd0);
        @(posedge clk); #1;
        chk("lat we next edge", {31'd0, bus.imem_we}, 32'd1);
        chk("lat wdata", bus.imem_wdata, 32'h00221820);
        chk("lat addr", bus.imem_addr, 32'h100);
        ack_en = 1'b1;
        @(posedge clk); #1;
        chk("lat count", {16'd0, word_count}, 32'd1);
        chk("lat addr+4", bus.imem_addr, 32'h104);

        // Encoding table, back-to-back acks.
        pulse(0);
        chk("restart count", {16'd0, word_count}, 32'd0);
        base = wr_n;
        for (int i = 0; i < NV; i++) send(vecs[i]);
        pulse(1);
        wait_done(1'b0);
        for (int i = 0; i < NV; i++) begin
            chk($sformatf("vec%0d data", i), log_d[base + i], vecs[i].exp);
            chk($sformatf("vec%0d addr", i), log_a[base + i], 32'h100 + 32'(4 * i));
        end
        chk("table count", {16'd0, word_count}, 32'(NV));
        chk("table writes", 32'(wr_n - base), 32'(NV));
        chk("done not busy", {31'd0, busy}, 32'd0);

        // Backpressure: ack held low until FIFO plus encode reg are full.
        ack_en = 1'b0;
        pulse(0);
        base = wr_n;
        acc = 0;
        bus.in_op = OP_ADDI; bus.in_rs = 5'd2; bus.in_rt = 5'd3;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.in_imm = 16'(acc);
            bus.in_valid = 1'b1;
            if (bus.in_ready) acc++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("bp accepted", 32'(acc), 32'd5);
        hold_a = bus.imem_addr;
        hold_d = bus.imem_wdata;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp hold%0d addr", i), bus.imem_addr, 32'h100);
            chk($sformatf("bp hold%0d data", i), bus.imem_wdata, 32'h20430000);
            chk($sformatf("bp hold%0d we/rdy", i), {30'd0, bus.imem_we, bus.in_ready}, 32'd2);
        end
        chk("bp stable", hold_a ^ bus.imem_addr | hold_d ^ bus.imem_wdata, 32'd0);
        ack_en = 1'b1;
        pulse(1);
        wait_done(1'b0);
        for (int i = 0; i < 5; i++)
            chk($sformatf("bp word%0d", i), log_d[base + i], 32'h20430000 + 32'(i));
        chk("bp count", {16'd0, word_count}, 32'd5);

        // Undefined op: accepted, dropped, flagged; start clears the flag.
        pulse(0);
        base = wr_n;
        v = vecs[0];
        v.op = 5'd31;
        send(v);
        pulse(1);
        wait_done(1'b0);
        chk("badop flag", {31'd0, err_badop}, 32'd1);
        chk("badop no write", 32'(wr_n - base) | {16'd0, word_count}, 32'd0);
        bus.in_valid = 1'b1;
        #1;
        chk("done in_ready", {31'd0, bus.in_ready}, 32'd0);
        bus.in_valid = 1'b0;
        pulse(0);
        chk("restart clears err", {31'd0, err_badop}, 32'd0);
        chk("restart state", {30'd0, busy, done}, 32'd2);
        chk("restart ovf", {31'd0, err_overflow}, 32'd0);

        // Overflow on the MAX_WORDS=2 instance.
        sel = 1'b1;
        pulse(2);
        for (int i = 0; i < 3; i++) send(vecs[15]);
        pulse(3);
        wait_done(1'b1);
        chk("ovf writes", 32'(wr2_n), 32'd2);
        chk("ovf flag", {31'd0, err_overflow2}, 32'd1);
        chk("ovf count", {16'd0, word_count2}, 32'd2);
        chk("ovf addr", bus2.imem_addr, 32'h8);
        chk("ovf no badop", {31'd0, err_badop2}, 32'd0);
        sel = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
